// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, op codes and iteration count for muldiv_seq.
package muldiv_pkg;
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FINISH, S_DZERO} state_t;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int ITER = 32;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the control unit and muldiv_seq.
interface muldiv_seq_if #(parameter int DATA_W = 32);
    logic              start;
    logic [1:0]        op;
    logic              abort;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic              hilo_write;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    modport master(output start, op, abort, operand_a, operand_b,
                   input busy, done, div_zero, hilo_write, hi_out, lo_out);
    modport slave(input start, op, abort, operand_a, operand_b,
                  output busy, done, div_zero, hilo_write, hi_out, lo_out);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on remainder/quotient registers.
module div_step #(parameter int DATA_W = 32) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    // rem < divisor keeps diff inside the signed DATA_W+1 range, so its MSB is the borrow
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        diff     = shifted - {1'b0, divisor};
        rem_next = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], ~diff[DATA_W]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-step MIPS MULT/DIV sequencer owning HI/LO.
// MULDIV_UNSIGNED_EN enables MULTU/DIVU via op[1]; otherwise every op is signed.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input logic         clock,
    input logic         reset,
    muldiv_seq_if.slave bus
);
    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   acc_hi, acc_lo, opnd;
    logic                neg_q, neg_r;
    logic                signed_op, a_neg, b_neg, b_zero, last, in_step;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   div_hi, div_lo, step_hi, step_lo, fin_hi, fin_lo;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic                busy_d, done_d, dz_d, hw_d;
    logic                busy, done, div_zero, hilo_write;
    logic [DATA_W-1:0]   hi_out, lo_out;

`ifdef MULDIV_UNSIGNED_EN
    assign signed_op = ~bus.op[1];
`else
    assign signed_op = 1'b1;
`endif

    assign a_neg   = signed_op & bus.operand_a[DATA_W-1];
    assign b_neg   = signed_op & bus.operand_b[DATA_W-1];
    assign mag_a   = a_neg ? -bus.operand_a : bus.operand_a;
    assign mag_b   = b_neg ? -bus.operand_b : bus.operand_b;
    assign b_zero  = bus.operand_b == '0;
    assign last    = cnt == CNT_W'(ITER - 1);
    assign in_step = state == S_MUL || state == S_DIV;

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem      (acc_hi),
        .quo      (acc_lo),
        .divisor  (opnd),
        .rem_next (div_hi),
        .quo_next (div_lo)
    );

    // shift-add multiply: multiplier drains out of acc_lo as the product shifts in
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        step_hi  = state == S_DIV ? div_hi : mul_sum[DATA_W:1];
        step_lo  = state == S_DIV ? div_lo : {mul_sum[0], acc_lo[DATA_W-1:1]};
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        fin_hi   = state == S_DIV ? (neg_r ? -step_hi : step_hi) : prod_fix[2*DATA_W-1:DATA_W];
        fin_lo   = state == S_DIV ? (neg_q ? -step_lo : step_lo) : prod_fix[DATA_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (bus.start && !bus.abort)
                              next_state = !bus.op[0] ? S_MUL : b_zero ? S_DZERO : S_DIV;
            S_MUL, S_DIV: next_state = bus.abort ? S_IDLE : last ? S_FINISH : state;
            default:      next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = next_state != S_IDLE;
        done_d = state == S_FINISH || state == S_DZERO;
        dz_d   = state == S_DZERO;
        hw_d   = state == S_FINISH;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hilo_write <= 1'b0;
            hi_out     <= '0;
            lo_out     <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            div_zero   <= dz_d;
            hilo_write <= hw_d;
            if (in_step && last && !bus.abort) begin
                hi_out <= fin_hi;
                lo_out <= fin_lo;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == S_IDLE) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
        end else begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.div_zero   = div_zero;
    assign bus.hilo_write = hilo_write;
    assign bus.hi_out     = hi_out;
    assign bus.lo_out     = lo_out;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the MIPS MULT/DIV family; owns the HI/LO result pair fed to the write-back mux.
- Takes operands from the A/B registers on a start pulse and runs a 32-step iteration: shift-add for multiply, restoring division for divide.
- Holds the control unit in a wait state via busy, pulses done on completion, and flags divide-by-zero for the exception path.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 DIV, 10 MULTU, 11 DIVU.
- abort  in  1  exception flush; cancels the operation in flight.
- operand_a  in  DATA_W  rs value / dividend.
- operand_b  in  DATA_W  rt value / divisor.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, concurrent with done, on divisor = 0.
- hilo_write  out  1  one-cycle pulse when hi_out/lo_out take a new result.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - state = IDLE, counter = 0.
  - hi_out = lo_out = 0; busy, done, div_zero, hilo_write = 0.
  - Reset overrides every other input in any state.
- States: IDLE, MUL, DIV, FINISH, DZERO.
- IDLE:
  - start = 1 with op[0] = 0: latch the operands and go to MUL.
  - start = 1 with op[0] = 1 and operand_b ≠ 0: latch the operands and go to DIV.
  - start = 1 with op[0] = 1 and operand_b = 0: go to DZERO.
  - Counter clears on entry to MUL or DIV.
- MUL / DIV:
  - Exactly one iteration per edge; the counter increments each edge.
  - The edge that completes iteration 32 registers the final, sign-corrected result into hi_out/lo_out and goes to FINISH.
  - start is ignored while busy.
- Signed operations work on operand magnitudes and then apply the sign fix:
  - Product: negated if the operand signs differ.
  - Quotient: truncated toward zero.
  - Remainder: takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0; no trap.
- Result mapping:
  - MULT: HI:LO = 64-bit product.
  - DIV: LO = quotient, HI = remainder.
- FINISH: done = 1 and hilo_write = 1 for one cycle, then IDLE.
- DZERO: done = 1 and div_zero = 1 for one cycle; hilo_write = 0 and HI/LO are unchanged; then IDLE.
- Latency:
  - Start accepted at edge E: done is high in the cycle after edge E+33.
  - Divide-by-zero: done is high in the cycle after edge E+1.
- abort:
  - abort = 1 in MUL or DIV: IDLE next edge; no done, no write; HI/LO keep their previous values.
  - abort in FINISH or DZERO is ignored.
  - abort in IDLE has priority over start, so no operation is started.
- All outputs are registered; the step logic has no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN.
- Defined: op[1] = 1 selects MULTU/DIVU, which skip the magnitude conversion and the sign fix.
- Undefined: op[1] is ignored and all operations are signed; unsigned-only logic is not synthesized.

Decomposition:
- Package muldiv_pkg holds:
  - State enum.
  - Op encodings: OP_MULT, OP_DIV, OP_MULTU, OP_DIVU.
  - ITER = 32.
- One natural sub-module, div_step: combinational restoring-division step.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and next quotient.
  - The multiply step stays inline.

Test Plan:
1. MULT 0xFFFFFFFF × 0x00000002 -> at cycle E+33: hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, done and hilo_write each high for 1 cycle.
2. MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
3. DIV −7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 7 / −2 -> lo = 0xFFFFFFFD, hi = 0x00000001.
4. Set hi/lo = 0x11/0x22, then DIV 5 / 0 -> done and div_zero high at E+1, no hilo_write, hi/lo still 0x11/0x22.
5. Start MULT, assert abort at E+10 -> IDLE at E+11; no done; hi/lo unchanged. A new start at E+12 is accepted.
6. Start held high for the whole operation -> exactly one done; pull reset low mid-DIV -> all outputs 0 and state IDLE after that edge. With MULDIV_UNSIGNED_EN: MULTU 0xFFFFFFFF × 2 -> hi = 0x00000001, lo = 0xFFFFFFFE.
